// File: rtl/aes_dec_ctrl.sv
// AES-128 iterative decryption controller.
// One inverse round per clock: the accept cycle adds round key 10, nine
// full inverse rounds follow, then a final round without InvMixColumns.
// Round keys come from an external store via rk_idx/rk_data (same-cycle lookup).
module aes_dec_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t       state, nxt_state;
  logic [3:0]   round_cnt, nxt_cnt;
  logic [127:0] state_reg, nxt_data;
  logic [127:0] sub_shift, add_rk, round_out;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then take the field inverse (x^254, 0 -> 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t, x2, x4, x8, x16, x32, x64, x128;
    t    = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    x2   = gf_mul(t, t);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
  endfunction

  // Byte i = row (i%4), column (i/4); byte 0 sits in the top bits
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 8*(4*c)     -: 8];
      a1 = s[127 - 8*(4*c + 1) -: 8];
      a2 = s[127 - 8*(4*c + 2) -: 8];
      a3 = s[127 - 8*(4*c + 3) -: 8];
      o[127 - 8*(4*c)     -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[127 - 8*(4*c + 1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[127 - 8*(4*c + 2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[127 - 8*(4*c + 3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Inverse round datapath; FINAL uses add_rk, ROUND uses round_out
  always_comb begin
    sub_shift = inv_sub_bytes(inv_shift_rows(state_reg));
    add_rk    = sub_shift ^ rk_data;
    round_out = inv_mix_columns(add_rk);
  end

  // State, round counter and data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_cnt <= 4'd0;
      state_reg <= '0;
    end else begin
      state     <= nxt_state;
      round_cnt <= nxt_cnt;
      state_reg <= nxt_data;
    end
  end

  // Next-state, next-data and handshake outputs; flush overrides everything
  always_comb begin
    nxt_state = state;
    nxt_cnt   = round_cnt;
    nxt_data  = state_reg;
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    out_data  = state_reg;
    rk_idx    = 4'd0;
    case (state)
      IDLE: begin
        rk_idx = 4'd10;
        if (in_valid) begin
          nxt_data  = in_data ^ rk_data;
          nxt_cnt   = 4'd9;
          nxt_state = ROUND;
        end
      end
      ROUND: begin
        rk_idx   = round_cnt;
        nxt_data = round_out;
        nxt_cnt  = round_cnt - 4'd1;
        if (round_cnt == 4'd1) nxt_state = FINAL;
      end
      FINAL: begin
        rk_idx    = 4'd0;
        nxt_data  = add_rk;
        nxt_state = DONE;
      end
      DONE: begin
        if (out_ready) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    if (flush) begin
      nxt_state = IDLE;
      nxt_cnt   = 4'd0;
      nxt_data  = state_reg;
    end
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Directed bench for aes_dec_ctrl using the FIPS-197 C.1 AES-128 vector.
module tb_aes_dec_ctrl;

  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  aes_dec_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key store: expanded schedule of key 000102030405060708090a0b0c0d0e0f
  always_comb begin
    rk_data = '0;
    case (rk_idx)
      4'd0:  rk_data = 128'h000102030405060708090a0b0c0d0e0f;
      4'd1:  rk_data = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      4'd2:  rk_data = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      4'd3:  rk_data = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      4'd4:  rk_data = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      4'd5:  rk_data = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      4'd6:  rk_data = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      4'd7:  rk_data = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      4'd8:  rk_data = 128'h47438735a41c65b9e016baf4aebf7ad2;
      4'd9:  rk_data = 128'h549932d1f08557681093ed9cbe2c974e;
      4'd10: rk_data = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      default: rk_data = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer CT from IDLE and run to DONE, checking rk_idx trace and latency.
  // Leaves the block in DONE with out_ready low.
  task automatic decrypt_fips(input string tag);
    int k;
    out_ready = 1'b0;
    in_data   = CT;
    in_valid  = 1'b1;
    chk({tag, "_acc_ready"}, 128'(in_ready), 128'(1'b1));
    chk({tag, "_rk_acc"}, 128'(rk_idx), 128'(4'd10));
    tick();
    in_valid = 1'b0;
    k = 1;
    while (out_valid !== 1'b1 && k < 20) begin
      chk({tag, "_rk_trace"}, 128'(rk_idx), (k <= 9) ? 128'(10 - k) : 128'(0));
      tick();
      k++;
    end
    chk({tag, "_latency"}, 128'(k), 128'(11));
    chk({tag, "_rk_done"}, 128'(rk_idx), 128'(4'd0));
    chk({tag, "_busy_done"}, 128'(busy), 128'(1'b1));
    chk({tag, "_pt"}, out_data, PT);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rel_ready"}, 128'(in_ready), 128'(1'b1));
    chk({tag, "_rel_valid"}, 128'(out_valid), 128'(1'b0));
    chk({tag, "_rel_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    int a1, a2, h1, h2, n_acc, n_hs;
    logic [127:0] d1, d2;
    logic saw_valid;

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(4'd10));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Basic decrypt, then back-pressure for 5 cycles
    decrypt_fips("fips1");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 128'(out_valid), 128'(1'b1));
      chk("bp_data", out_data, PT);
      chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
      chk("bp_busy", 128'(busy), 128'(1'b1));
    end
    release_out("bp");

    // Flush on the 5th ROUND cycle
    in_data = CT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("fl_rk_round5", 128'(rk_idx), 128'(4'd5));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_in_ready", 128'(in_ready), 128'(1'b1));
    chk("fl_busy", 128'(busy), 128'(1'b0));
    chk("fl_rk_idx", 128'(rk_idx), 128'(4'd10));
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) saw_valid = 1'b1;
      tick();
    end
    chk("fl_no_valid", 128'(saw_valid), 128'(1'b0));
    decrypt_fips("fips2");

    // Flush in DONE beats out_ready and leaves the data register alone
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("fld_in_ready", 128'(in_ready), 128'(1'b1));
    chk("fld_valid", 128'(out_valid), 128'(1'b0));
    chk("fld_data_kept", out_data, PT);

    // Flush beats accept in IDLE
    in_data = CT; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fli_idle", 128'(in_ready), 128'(1'b1));
    chk("fli_busy", 128'(busy), 128'(1'b0));

    // out_ready with nothing valid changes nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("or_idle_valid", 128'(out_valid), 128'(1'b0));
    chk("or_idle_ready", 128'(in_ready), 128'(1'b1));

    // Asynchronous reset mid-ROUND
    in_data = CT; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("ar_busy_before", 128'(busy), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'(1'b0));
    chk("ar_in_ready", 128'(in_ready), 128'(1'b1));
    chk("ar_busy", 128'(busy), 128'(1'b0));
    chk("ar_out_data", out_data, 128'd0);
    chk("ar_rk_idx", 128'(rk_idx), 128'(4'd10));
    #3 rst_n = 1'b1;
    tick();
    decrypt_fips("fips3");
    release_out("fips3");

    // Back-to-back with in_valid and out_ready held high
    a1 = -1; a2 = -1; h1 = -1; h2 = -1; n_acc = 0; n_hs = 0;
    d1 = '0; d2 = '0;
    in_data = CT; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && n_hs < 2; cyc++) begin
      if (in_valid && in_ready) begin
        if (n_acc == 0) a1 = cyc; else if (n_acc == 1) a2 = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        if (n_hs == 0) begin h1 = cyc; d1 = out_data; end
        else begin h2 = cyc; d2 = out_data; end
        n_hs++;
      end
      if (n_hs < 2) tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("b2b_first_acc", 128'(a1), 128'(0));
    chk("b2b_latency", 128'(h1 - a1), 128'(11));
    chk("b2b_second_acc", 128'(a2), 128'(h1 + 1));
    chk("b2b_second_lat", 128'(h2 - a2), 128'(11));
    chk("b2b_pt1", d1, PT);
    chk("b2b_pt2", d2, PT);
    chk("b2b_end_idle", 128'(in_ready), 128'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
